fifo_word_packer: RTL and testbench

FIFO_WORD_PACKER -- requirements
Module: fifo_word_packer

---
 rtl/fifo_word_packer_if.sv | 29 ++
 rtl/fifo_word_packer.sv | 133 +++++++++++++
 tb/tb_fifo_word_packer.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_word_packer_if.sv
// Bus bundle between the byte FIFO, the word packer and the word consumer.
// The packer takes the master view; the surrounding environment takes the slave view.
interface fifo_word_packer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
);
    localparam int OUT_WIDTH = DATA_WIDTH * LANES;
    localparam int BW        = $clog2(LANES + 1);

    logic                  fifo_rd_en;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic                  fifo_empty;
    logic                  flush;
    logic                  m_valid;
    logic                  m_ready;
    logic [OUT_WIDTH-1:0]  m_data;
    logic [BW-1:0]         m_bytes;
    logic [15:0]           words_sent;

    modport master (
        output fifo_rd_en, m_valid, m_data, m_bytes, words_sent,
        input  fifo_rdata, fifo_empty, flush, m_ready
    );

    modport slave (
        input  fifo_rd_en, m_valid, m_data, m_bytes, words_sent,
        output fifo_rdata, fifo_empty, flush, m_ready
    );
endinterface

// File: rtl/fifo_word_packer.sv
// Packs bytes read from an upstream FIFO into little-endian output words of
// LANES lanes. A flush pulse emits a partially assembled word with unused
// lanes zeroed; m_bytes reports how many lanes carry data.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | normal operation: read while lanes are free, emit full words
// FLUSH | no new reads; wait for the in-flight byte, then emit partial word
module fifo_word_packer #(
    parameter int DATA_WIDTH = 8,
    parameter int LANES      = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    fifo_word_packer_if.master  bus
);
    localparam int OUT_WIDTH = DATA_WIDTH * LANES;
    localparam int CW        = $clog2(LANES + 1);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);
    localparam logic [CW:0]   LANES_W = (CW + 1)'(LANES);

    typedef enum logic {
        FILL  = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [OUT_WIDTH-1:0]  asm_q, asm_d;
    logic [OUT_WIDTH-1:0]  data_q, data_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         bytes_q, bytes_d;
    logic                  pend_q, pend_d;
    logic                  valid_q, valid_d;
    logic [15:0]           words_q, words_d;

    logic [CW:0]           occupancy;
    logic [CW-1:0]         base_cnt;
    logic                  flush_req;
    logic                  rd_en;
    logic                  out_free;
    logic                  xfer;

    // Lanes already filled plus the byte still in flight from the FIFO.
    assign flush_req = (state_q == FLUSH);
    assign occupancy = {1'b0, cnt_q} + {{CW{1'b0}}, pend_q};

    // Gated by rst_n so the FIFO is never popped while reset is held.
    assign rd_en    = rst_n && !bus.fifo_empty && !flush_req && (occupancy < LANES_W);
    assign out_free = !valid_q || bus.m_ready;

    // A full word always moves out; a partial one only when flushing and
    // the last requested byte has landed.
    assign xfer = out_free &&
                  ((cnt_q == LANES_C) || (flush_req && !pend_q && (cnt_q != '0)));

    // Next-state logic: enter FLUSH only if there is something to emit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            FILL: begin
                if (bus.flush && (occupancy != '0)) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (xfer || (!pend_q && (cnt_q == '0))) begin
                    state_d = FILL;
                end
            end
            default: state_d = FILL;
        endcase
    end

    // Assembly, output register and counter next-state.
    always_comb begin
        base_cnt = xfer ? '0 : cnt_q;
        asm_d    = xfer ? '0 : asm_q;
        cnt_d    = base_cnt;
        pend_d   = rd_en;
        data_d   = data_q;
        bytes_d  = bytes_q;
        valid_d  = valid_q;

        // A landing byte goes into the next free lane of the (possibly fresh) assembly.
        if (pend_q) begin
            for (int l = 0; l < LANES; l++) begin
                if (int'(base_cnt) == l) begin
                    asm_d[l*DATA_WIDTH +: DATA_WIDTH] = bus.fifo_rdata;
                end
            end
            cnt_d = base_cnt + CW'(1);
        end

        if (xfer) begin
            data_d  = asm_q;
            bytes_d = cnt_q;
            valid_d = 1'b1;
        end else if (bus.m_ready) begin
            valid_d = 1'b0;
        end

        words_d = words_q + ((valid_q && bus.m_ready) ? 16'd1 : 16'd0);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= FILL;
            asm_q   <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            bytes_q <= '0;
            pend_q  <= 1'b0;
            valid_q <= 1'b0;
            words_q <= '0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
            bytes_q <= bytes_d;
            pend_q  <= pend_d;
            valid_q <= valid_d;
            words_q <= words_d;
        end
    end

    assign bus.fifo_rd_en = rd_en;
    assign bus.m_valid    = valid_q;
    assign bus.m_data     = data_q;
    assign bus.m_bytes    = bytes_q;
    assign bus.words_sent = words_q;
endmodule

// File: tb/tb_fifo_word_packer.sv
// Bench for fifo_word_packer: directed scenarios plus a randomized stream,
// checked against a queue-based FIFO model and a byte-stream scoreboard.
module tb_fifo_word_packer;
    localparam int DW = 8;
    localparam int LN = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fifo_word_packer_if #(.DATA_WIDTH(DW), .LANES(LN)) bus ();
    fifo_word_packer #(.DATA_WIDTH(DW), .LANES(LN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          total = 0;
    int          bad   = 0;
    byte unsigned fifo_q[$];
    byte unsigned in_stream[$];
    byte unsigned out_stream[$];
    logic [31:0] cap_data[$];
    int          cap_bytes[$];
    logic [15:0] exp_words = '0;
    int          reads = 0;
    bit          rand_mode = 1'b0;
    bit          ready_hold = 1'b0;
    bit          holding = 1'b0;
    logic [31:0] hold_data;
    logic [2:0]  hold_bytes;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample at negedge, then update inputs just after posedge.
    task automatic cycle();
        byte unsigned b;
        bit got;
        got = 1'b0;
        b = 8'h00;
        @(negedge clk);
        chk("words_sent", bus.words_sent, exp_words);
        if (bus.fifo_empty === 1'b1) chk("rd_while_empty", bus.fifo_rd_en, 1'b0);
        if (rst_n === 1'b0) chk("rd_in_reset", bus.fifo_rd_en, 1'b0);
        if (holding) begin
            chk("hold_valid", bus.m_valid, 1'b1);
            chk("hold_data", bus.m_data, hold_data);
            chk("hold_bytes", bus.m_bytes, hold_bytes);
        end
        if (bus.fifo_rd_en === 1'b1 && fifo_q.size() > 0) begin
            b = fifo_q.pop_front();
            got = 1'b1;
            reads++;
        end
        if (rst_n === 1'b0) begin
            exp_words = '0;
            holding = 1'b0;
        end else begin
            if (bus.m_valid === 1'b1 && bus.m_ready === 1'b1) begin
                cap_data.push_back(bus.m_data);
                cap_bytes.push_back(int'(bus.m_bytes));
                for (int i = 0; i < int'(bus.m_bytes); i++)
                    out_stream.push_back(bus.m_data[i*8 +: 8]);
                exp_words = exp_words + 16'd1;
            end
            holding = (bus.m_valid === 1'b1) && (bus.m_ready === 1'b0);
            hold_data = bus.m_data;
            hold_bytes = bus.m_bytes;
        end
        @(posedge clk);
        #1;
        bus.fifo_rdata = got ? b : 8'($urandom);
        if (got) in_stream.push_back(b);
        bus.flush = 1'b0;
        bus.fifo_empty = (fifo_q.size() == 0) || (rand_mode && $urandom_range(0, 2) == 0);
        bus.m_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_hold;
    endtask

    task automatic push(input byte unsigned b);
        fifo_q.push_back(b);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic wait_words(input int n, input int budget);
        int k;
        k = 0;
        while (cap_data.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk("wait_words", cap_data.size() >= n, 1'b1);
    endtask

    task automatic stream_check(input string tag);
        int mism;
        mism = 0;
        chk({tag, "_len"}, out_stream.size(), in_stream.size());
        for (int i = 0; i < in_stream.size() && i < out_stream.size(); i++)
            if (in_stream[i] !== out_stream[i]) mism++;
        chk({tag, "_mism"}, mism, 0);
    endtask

    initial begin
        int r0;
        int w0;
        int odd;
        rst_n = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_rdata = '0;
        bus.flush = 1'b0;
        bus.m_ready = 1'b0;
        cycle();
        cycle();
        chk("rst_valid", bus.m_valid, 1'b0);
        chk("rst_data", bus.m_data, 32'h0);
        chk("rst_bytes", bus.m_bytes, 3'd0);
        chk("rst_words", bus.words_sent, 16'd0);
        chk("rst_rd_en", bus.fifo_rd_en, 1'b0);
        rst_n = 1'b1;

        // Basic full word, no back-pressure.
        ready_hold = 1'b1;
        bus.m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        wait_words(1, 30);
        chk("w1_data", cap_data[0], 32'h44332211);
        chk("w1_bytes", cap_bytes[0], 4);
        chk("w1_valid_drop", bus.m_valid, 1'b0);
        chk("w1_count", bus.words_sent, 16'd1);

        // Back-pressure: second word assembles behind the held one, reads stop.
        ready_hold = 1'b0;
        bus.m_ready = 1'b0;
        r0 = reads;
        for (int i = 1; i <= 9; i++) push(8'(i));
        repeat (16) cycle();
        chk("bp_valid", bus.m_valid, 1'b1);
        chk("bp_data", bus.m_data, 32'h04030201);
        chk("bp_bytes", bus.m_bytes, 3'd4);
        chk("bp_reads", reads - r0, 8);
        chk("bp_rd_stop", bus.fifo_rd_en, 1'b0);
        chk("bp_left", fifo_q.size(), 1);
        ready_hold = 1'b1;
        bus.m_ready = 1'b1;
        wait_words(3, 40);
        chk("bp_w2", cap_data[1], 32'h04030201);
        chk("bp_w3", cap_data[2], 32'h08070605);
        repeat (4) cycle();
        bus.flush = 1'b1;
        cycle();
        wait_words(4, 20);
        chk("fl1_data", cap_data[3], 32'h00000009);
        chk("fl1_bytes", cap_bytes[3], 1);
        chk("fl1_count", bus.words_sent, 16'd4);

        // Partial flush after FIFO runs dry.
        push(8'hAA); push(8'hBB);
        repeat (5) cycle();
        bus.flush = 1'b1;
        cycle();
        wait_words(5, 20);
        chk("fl2_data", cap_data[4], 32'h0000BBAA);
        chk("fl2_bytes", cap_bytes[4], 2);

        // Flush with nothing assembled is ignored; packing continues normally.
        repeat (3) cycle();
        bus.flush = 1'b1;
        cycle();
        repeat (5) cycle();
        chk("idle_flush_words", cap_data.size(), 5);
        chk("idle_flush_valid", bus.m_valid, 1'b0);
        push(8'hD1); push(8'hD2); push(8'hD3); push(8'hD4);
        wait_words(6, 30);
        chk("after_idle_data", cap_data[5], 32'hD4D3D2D1);
        chk("after_idle_bytes", cap_bytes[5], 4);

        // Flush coincident with the read of the third byte keeps that byte.
        push(8'hAA); push(8'hBB); push(8'hCC); push(8'hDD);
        cycle();
        cycle();
        r0 = reads;
        bus.flush = 1'b1;
        cycle();
        chk("fl3_read", reads - r0, 1);
        wait_words(7, 20);
        chk("fl3_data", cap_data[6], 32'h00CCBBAA);
        chk("fl3_bytes", cap_bytes[6], 3);
        repeat (5) cycle();
        bus.flush = 1'b1;
        cycle();
        wait_words(8, 20);
        chk("fl4_data", cap_data[7], 32'h000000DD);
        chk("fl4_bytes", cap_bytes[7], 1);
        stream_check("directed");

        // Reset mid-assembly discards the partial word.
        push(8'h5A); push(8'h5B);
        repeat (5) cycle();
        rst_n = 1'b0;
        cycle();
        rst_n = 1'b1;
        chk("mid_rst_valid", bus.m_valid, 1'b0);
        chk("mid_rst_data", bus.m_data, 32'h0);
        chk("mid_rst_bytes", bus.m_bytes, 3'd0);
        chk("mid_rst_words", bus.words_sent, 16'd0);
        in_stream.delete();
        out_stream.delete();
        push(8'hC1); push(8'hC2); push(8'hC3); push(8'hC4);
        wait_words(9, 30);
        chk("post_rst_data", cap_data[8], 32'hC4C3C2C1);
        chk("post_rst_bytes", cap_bytes[8], 4);
        chk("post_rst_words", bus.words_sent, 16'd1);

        // Randomized empty/ready patterns over 1000 bytes.
        in_stream.delete();
        out_stream.delete();
        rand_mode = 1'b1;
        w0 = cap_data.size();
        for (int i = 0; i < 1000; i++) fifo_q.push_back(8'($urandom));
        wait_words(w0 + 250, 20000);
        rand_mode = 1'b0;
        ready_hold = 1'b1;
        bus.m_ready = 1'b1;
        repeat (4) cycle();
        odd = 0;
        for (int i = w0; i < cap_bytes.size(); i++)
            if (cap_bytes[i] != 4) odd++;
        chk("rand_partial_words", odd, 0);
        chk("rand_words", bus.words_sent, 16'd251);
        chk("rand_fifo_drained", fifo_q.size(), 0);
        stream_check("rand");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
